// File: rtl/clint_pkg.sv
// Shared constants and types for the CLINT register block.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_OFFSET  = 16'hBFF8;

    typedef logic [63:0] mtime_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } reg_sel_e;

endpackage

// File: rtl/clint_rtc_tick.sv
// RTC rising-edge detector producing a one-cycle tick.
// Define CLINT_RTC_SYNC_EN to insert a 2-flop synchroniser for an asynchronous RTC.
module clint_rtc_tick (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rtc_i,
    output logic tick_o
);

    logic rtc_s;
    logic rtc_prev_q;

`ifdef CLINT_RTC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rtc_i};
        end
    end

    assign rtc_s = sync_q[1];
`else
    assign rtc_s = rtc_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtc_prev_q <= 1'b0;
        end else begin
            rtc_prev_q <= rtc_s;
        end
    end

    assign tick_o = rtc_s & ~rtc_prev_q;

endmodule

// File: rtl/clint_regs.sv
// CLINT register/timer back end: MSIP, MTIMECMP, MTIME and interrupt outputs.
// Optional CLINT_RTC_SYNC_EN synchronises rtc_i inside clint_rtc_tick.
module clint_regs
    import clint_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned NR_CORES       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rtc_i,
    input  logic [AXI_ADDR_WIDTH-1:0] address_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    output logic [NR_CORES-1:0]       timer_irq_o,
    output logic [NR_CORES-1:0]       ipi_o
);

    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("clint_regs: AXI_DATA_WIDTH must be 64");
    end
    if (NR_CORES < 1 || NR_CORES > 32) begin : g_bad_nr_cores
        $error("clint_regs: NR_CORES must be in 1..32");
    end

    localparam logic [12:0] MSIP_WORD     = MSIP_BASE[15:3];
    localparam logic [12:0] MTIMECMP_WORD = MTIMECMP_BASE[15:3];
    localparam logic [12:0] MTIME_WORD    = MTIME_OFFSET[15:3];
    localparam logic [12:0] NR_MSIP_WORDS = 13'((NR_CORES + 1) / 2);
    localparam logic [12:0] NR_CMP_WORDS  = 13'(NR_CORES);

    logic [12:0]         word;
    logic [12:0]         msip_off;
    logic [12:0]         cmp_off;
    logic                unused_addr;
    reg_sel_e            sel;
    logic                wr_en;
    logic                tick;

    mtime_t              mtime_q, mtime_d;
    mtime_t              mtimecmp_q [NR_CORES];
    mtime_t              mtimecmp_d [NR_CORES];
    logic [NR_CORES-1:0] msip_q, msip_d;
    logic [NR_CORES-1:0] irq_q, irq_d;

    assign word        = address_i[15:3];
    assign unused_addr = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};
    // Offsets wrap below the base, so a single unsigned bound check covers both ends.
    assign msip_off    = word - MSIP_WORD;
    assign cmp_off     = word - MTIMECMP_WORD;
    assign wr_en       = en_i & we_i;

    clint_rtc_tick u_rtc_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rtc_i  (rtc_i),
        .tick_o (tick)
    );

    always_comb begin
        sel = SEL_NONE;
        if (msip_off < NR_MSIP_WORDS) begin
            sel = SEL_MSIP;
        end else if (cmp_off < NR_CMP_WORDS) begin
            sel = SEL_MTIMECMP;
        end else if (word == MTIME_WORD) begin
            sel = SEL_MTIME;
        end
    end

    always_comb begin
        data_o = '0;
        if (en_i) begin
            case (sel)
                SEL_MSIP: begin
                    for (int unsigned h = 0; h < NR_CORES; h++) begin
                        if (msip_off == 13'(h / 2)) data_o[(h % 2) * 32] = msip_q[h];
                    end
                end
                SEL_MTIMECMP: begin
                    for (int unsigned h = 0; h < NR_CORES; h++) begin
                        if (cmp_off == 13'(h)) data_o = mtimecmp_q[h];
                    end
                end
                SEL_MTIME: data_o = mtime_q;
                default:   data_o = '0;
            endcase
        end
    end

    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en && sel == SEL_MTIME) mtime_d = data_i;

        msip_d = msip_q;
        for (int unsigned h = 0; h < NR_CORES; h++) begin
            if (wr_en && sel == SEL_MSIP && msip_off == 13'(h / 2)) begin
                msip_d[h] = data_i[(h % 2) * 32];
            end
            mtimecmp_d[h] = (wr_en && sel == SEL_MTIMECMP && cmp_off == 13'(h))
                          ? data_i : mtimecmp_q[h];
            irq_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
            msip_q  <= '0;
            irq_q   <= '0;
            for (int unsigned h = 0; h < NR_CORES; h++) mtimecmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_d;
            msip_q  <= msip_d;
            irq_q   <= irq_d;
            for (int unsigned h = 0; h < NR_CORES; h++) mtimecmp_q[h] <= mtimecmp_d[h];
        end
    end

    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;

endmodule

// File: tb/tb_clint_regs.sv
// Randomised self-checking bench for clint_regs (NR_CORES = 2) against a behavioural model.
// Honours CLINT_RTC_SYNC_EN for the expected RTC tick latency.
module tb_clint_regs;

    localparam int unsigned NR = 2;
`ifdef CLINT_RTC_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i, rtc_i, en_i, we_i;
    logic [63:0]   address_i, data_i, data_o;
    logic [NR-1:0] timer_irq_o, ipi_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic rtc_lvl = 1'b0;

    // Reference model state
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NR];
    logic [NR-1:0] m_msip, m_irq;
    bit            hist[$];

    clint_regs #(
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .NR_CORES       (NR)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rtc_i       (rtc_i),
        .address_i   (address_i),
        .en_i        (en_i),
        .we_i        (we_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .timer_irq_o (timer_irq_o),
        .ipi_o       (ipi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mtime = 64'd0;
        for (int h = 0; h < NR; h++) m_cmp[h] = '1;
        m_msip = '0;
        m_irq  = '0;
        hist   = '{0, 0, 0};
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [15:0]  lo;
        int unsigned  w;
        logic [63:0]  r;
        lo = a[15:0];
        w  = lo / 8;
        r  = 64'd0;
        if (w < (NR + 1) / 2) begin
            if (2 * w < NR)     r[0]  = m_msip[2 * w];
            if (2 * w + 1 < NR) r[32] = m_msip[2 * w + 1];
        end else if (w >= 'h4000 / 8 && w < 'h4000 / 8 + NR) begin
            r = m_cmp[w - 'h4000 / 8];
        end else if (w == 'hBFF8 / 8) begin
            r = m_mtime;
        end
        return r;
    endfunction

    function automatic void model_edge(input logic r, input logic [63:0] a, input logic e,
                                       input logic w, input logic [63:0] d, input logic rt);
        logic [15:0] lo;
        int unsigned wd;
        bit          tick;
        int          n;
        if (r) begin
            model_reset();
            return;
        end
        hist.push_back(rt);
        if (hist.size() > 8) void'(hist.pop_front());
        n    = hist.size();
        tick = hist[n - 1 - LAT] && !hist[n - 2 - LAT];
        for (int h = 0; h < NR; h++) m_irq[h] = (m_mtime >= m_cmp[h]);
        if (tick) m_mtime = m_mtime + 64'd1;
        if (e && w) begin
            lo = a[15:0];
            wd = lo / 8;
            if (wd < (NR + 1) / 2) begin
                for (int unsigned h = 0; h < NR; h++)
                    if (h / 2 == wd) m_msip[h] = (h % 2 == 1) ? d[32] : d[0];
            end else if (wd >= 'h4000 / 8 && wd < 'h4000 / 8 + NR) begin
                m_cmp[wd - 'h4000 / 8] = d;
            end else if (wd == 'hBFF8 / 8) begin
                m_mtime = d;
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic [63:0] a, input logic e, input logic w,
                       input logic [63:0] d, output logic [63:0] obs);
        rst_i = r; address_i = a; en_i = e; we_i = w; data_i = d; rtc_i = rtc_lvl;
        @(negedge clk_i);
        obs = data_o;
        if (!r) begin
            if (!e)      check("idle_rdata", data_o, 64'd0);
            else if (!w) check("rdata", data_o, model_read(a));
        end
        @(posedge clk_i);
        model_edge(r, a, e, w, d, rtc_lvl);
        #1;
        check("ipi", 64'(ipi_o), 64'(m_msip));
        check("irq", 64'(timer_irq_o), 64'(m_irq));
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        logic [63:0] obs;
        cyc(1'b0, a, 1'b1, 1'b1, d, obs);
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] obs);
        cyc(1'b0, a, 1'b1, 1'b0, 64'd0, obs);
    endtask

    task automatic rd_exp(input string tag, input logic [63:0] a, input logic [63:0] exp);
        logic [63:0] obs;
        rd(a, obs);
        check(tag, obs, exp);
    endtask

    task automatic idle(input int n);
        logic [63:0] obs;
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, obs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] obs;
        logic [15:0] tbl [8];
        int          lat_seen;
        tbl = '{16'h0000, 16'h0008, 16'h2000, 16'h4000, 16'h4008, 16'h4010, 16'hBFF8, 16'hBFF0};
        model_reset();

        // Reset state
        cyc(1'b1, 64'd0, 1'b0, 1'b0, 64'd0, obs);
        cyc(1'b1, 64'd0, 1'b0, 1'b0, 64'd0, obs);
        rd_exp("rst_mtime", 64'hBFF8, 64'd0);
        rd_exp("rst_cmp0", 64'h4000, '1);
        rd_exp("rst_msip", 64'h0000, 64'd0);

        // Software interrupts
        wr(64'h0000, 64'h0000_0001_0000_0001);
        check("ipi_set", 64'(ipi_o), 64'h3);
        rd_exp("msip_rb", 64'h0000, 64'h0000_0001_0000_0001);
        wr(64'h0000, 64'd0);
        check("ipi_clr", 64'(ipi_o), 64'h0);

        // Five RTC rising edges, one held high for 10 cycles
        for (int i = 0; i < 5; i++) begin
            rtc_lvl = 1'b1;
            idle(i == 2 ? 10 : 1);
            rtc_lvl = 1'b0;
            idle(2);
        end
        idle(3);
        rd_exp("mtime_5", 64'hBFF8, 64'd5);

        // Tick latency
        wr(64'hBFF8, 64'd100);
        rtc_lvl = 1'b1;
        rd(64'hBFF8, obs);
        lat_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            rd(64'hBFF8, obs);
            if (obs == 64'd101 && lat_seen == 0) lat_seen = k;
        end
        check("tick_latency", 64'(lat_seen), 64'(1 + LAT));
        rtc_lvl = 1'b0;
        idle(3);

        // Timer interrupt
        wr(64'h4000, 64'd3);
        wr(64'hBFF8, 64'd0);
        for (int i = 0; i < 3; i++) begin
            rtc_lvl = 1'b1;
            idle(1);
            rtc_lvl = 1'b0;
            idle(1);
        end
        idle(LAT + 2);
        check("irq_set", 64'(timer_irq_o[0]), 64'd1);
        wr(64'h4000, 64'd10);
        check("irq_hold", 64'(timer_irq_o[0]), 64'd1);
        idle(1);
        check("irq_drop", 64'(timer_irq_o[0]), 64'd0);

        // Wrap-around
        wr(64'hBFF8, '1);
        rtc_lvl = 1'b1;
        idle(1);
        rtc_lvl = 1'b0;
        idle(LAT + 1);
        rd_exp("mtime_wrap", 64'hBFF8, 64'd0);

        // Write collides with tick
        rtc_lvl = 1'b1;
        idle(LAT);
        wr(64'hBFF8, 64'd7);
        rtc_lvl = 1'b0;
        idle(LAT + 2);
        rd_exp("mtime_collide", 64'hBFF8, 64'd7);

        // Unmapped addresses
        wr(64'h2000, 64'hDEAD_BEEF_DEAD_BEEF);
        wr(64'h4000 + 8 * NR, 64'h1234);
        wr(64'h0008, 64'h0000_0001_0000_0001);
        rd_exp("unmap_2000", 64'h2000, 64'd0);
        rd_exp("unmap_cmp", 64'h4000 + 8 * NR, 64'd0);
        rd_exp("keep_mtime", 64'hBFF8, 64'd7);
        rd_exp("keep_cmp0", 64'h4000, 64'd10);
        rd_exp("keep_cmp1", 64'h4008, '1);
        rd_exp("keep_msip", 64'h0000, 64'd0);

        // Reset during a write
        wr(64'h4000, 64'd55);
        cyc(1'b1, 64'h4000, 1'b1, 1'b1, 64'd99, obs);
        rd_exp("rstw_cmp0", 64'h4000, '1);
        rd_exp("rstw_mtime", 64'hBFF8, 64'd0);
        check("rstw_irq", 64'(timer_irq_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a, d;
            logic        r, e, w;
            a = {$urandom, $urandom};
            a[15:0] = tbl[$urandom_range(0, 7)] | 16'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    d = 64'($urandom_range(0, 40));
                2:       d = '1 - 64'($urandom_range(0, 3));
                default: d = {$urandom, $urandom};
            endcase
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) rtc_lvl = ~rtc_lvl;
            cyc(r, a, e, w, d, obs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_regs.md
Name: clint_regs

Overview:
- Register/timer back end of the CLINT. Sits directly downstream of the AXI-Lite slave FSM and consumes its RAM-like strobe interface (address, enable, write, write data). Returns read data combinationally.
- Holds the per-hart MSIP bits, the per-hart MTIMECMP registers and the shared MTIME counter.
- MTIME advances on rising edges of the RTC input.
- Drives the per-hart timer and software interrupt lines.

Parameters:
- AXI_ADDR_WIDTH, 64, width of address_i; only bits [15:0] are decoded.
- AXI_DATA_WIDTH, 64, read/write data width; must be 64. Elaboration error otherwise.
- NR_CORES, 1, number of harts (1..32).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- rtc_i  in  1  real-time clock; each rising edge increments MTIME.
- address_i  in  AXI_ADDR_WIDTH  byte address of the access.
- en_i  in  1  access valid this cycle.
- we_i  in  1  1 = write, 0 = read (qualified by en_i).
- data_i  in  AXI_DATA_WIDTH  write data.
- data_o  out  AXI_DATA_WIDTH  read data, combinational from address_i.
- timer_irq_o  out  NR_CORES  machine timer interrupt per hart.
- ipi_o  out  NR_CORES  machine software interrupt per hart (= MSIP).

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high (rst_i); all state changes on the rising edge of clk_i.
- Reset values:
  - mtime = 0.
  - mtimecmp[h] = all ones.
  - msip = 0.
  - timer_irq_o = 0; ipi_o = 0.
  - RTC edge and synchroniser flops = 0.
  - data_o is 0 whenever en_i = 0.
- Address map, in 64-bit words, index = address_i[15:3]; address_i[2:0] ignored except as noted:
  - MSIP: 0x0000 + 8k, for k < ceil(NR_CORES/2). Bit 0 holds hart 2k; bit 32 holds hart 2k+1. All other bits read 0 and are ignored on write.
  - MTIMECMP[h]: 0x4000 + 8h, for h < NR_CORES. Full 64 bits.
  - MTIME: 0xBFF8. Full 64 bits.
  - Any other address: reads return 0; writes are ignored. No error is signalled.
- Reads (en_i = 1, we_i = 0): data_o reflects the register's current value in the same cycle (zero latency). The upstream FSM samples data_o in the cycle it asserts r_valid.
- Writes (en_i = 1, we_i = 1): single cycle, full 64-bit, no byte strobes. The new value is visible from the next cycle.
- RTC tick:
  - tick = rtc sample high AND previous sample low.
  - Each tick increments mtime by 1, modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - Without sync, a rising edge of rtc_i sampled at edge t increments mtime at edge t (visible at t+1).
  - rtc held high produces one tick only.
- MTIME write coinciding with a tick: the written value wins and the increment is dropped.
- Timer interrupt:
  - timer_irq_o[h] is registered: next value = (mtime >= mtimecmp[h]), unsigned 64-bit compare on current register values.
  - A write to mtimecmp or mtime at edge t affects timer_irq_o at edge t+1, i.e. it is visible 2 cycles after the write cycle.
- ipi_o[h] = msip[h], direct from the flop. Asserts 1 cycle after the write.
- Reset asserted mid-operation: all state returns to the reset values on that edge. The access presented in that cycle is discarded.

Optional Feature:
- Macro: CLINT_RTC_SYNC_EN.
- Defined: rtc_i passes through a 2-flop synchroniser before edge detection, for an asynchronous RTC. This adds 2 cycles of tick latency; increment is visible at t+3.
- Undefined: rtc_i is treated as synchronous to clk_i. Edge detection only, one flop.

Decomposition:
- clint_pkg holds:
  - the MSIP_BASE (16'h0000), MTIMECMP_BASE (16'h4000) and MTIME_OFFSET (16'hBFF8) constants;
  - the 64-bit mtime_t typedef.
- Sub-module clint_rtc_tick: optional synchroniser plus rising-edge detector. Single-cycle tick output; reset on rst_i.
- Decode, register file, counter and compare stay in clint_regs.

Test Plan:
- Reset then read 0xBFF8, 0x4000, 0x0000 → 0, 0xFFFF_FFFF_FFFF_FFFF, 0. timer_irq_o = 0, ipi_o = 0.
- NR_CORES = 2: write 0x0000 with data 0x0000_0001_0000_0001 → ipi_o = 2'b11 one cycle later. Read back gives the same value. Write 0 → ipi_o = 0.
- Toggle rtc_i 5 rising edges, including one held high for 10 cycles → mtime = 5. Repeat with CLINT_RTC_SYNC_EN defined and check the 2-cycle extra latency.
- Write mtimecmp[0] = 3 with mtime = 0, then 3 RTC edges → timer_irq_o[0] rises exactly 1 cycle after mtime becomes 3. Write mtimecmp[0] = 10 → irq drops 2 cycles after the write.
- Write mtime = 0xFFFF_FFFF_FFFF_FFFF, then one tick → mtime = 0. Write mtime = 7 in the same cycle as a tick → mtime = 7.
- Read/write 0x2000 and 0x4000 + 8·NR_CORES → read 0, no register changes. Assert rst_i during a write → write discarded, all state at reset values.
